// File: rtl/sub1_iter.sv
// Slice-serial subtractor: Z = A - B over WIDTH/SLICE cycles behind valid/ready handshakes.
// Optional build macro SUB1_SAT_EN saturates the result on unsigned borrow or signed overflow.
module sub1_iter #(
  parameter int WIDTH = 64,
  parameter int SLICE = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Z,
  output logic             borrow,
  output logic             ovf
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST_SLICE = CW'(NSLICE - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic             w_accept;
  logic             w_last;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_signed;
  logic [CW-1:0]    r_cnt;
  logic             r_bin;
  logic [WIDTH-1:0] r_z;
  logic             r_borrow;
  logic             r_ovf;

  logic [SLICE-1:0] w_a_sl;
  logic [SLICE-1:0] w_b_sl;
  logic [SLICE-1:0] w_diff;
  logic             w_bout;
  logic             w_ovf;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    w_accept  = 1'b0;
    w_last    = 1'b0;
    unique case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept = 1'b1;
          w_next   = BUSY;
        end
      end
      BUSY: begin
        if (r_cnt == LAST_SLICE) begin
          w_last = 1'b1;
          w_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // One slice per cycle; the extra top bit of the widened difference is the slice borrow-out.
  assign w_a_sl = r_a[int'(r_cnt) * SLICE +: SLICE];
  assign w_b_sl = r_b[int'(r_cnt) * SLICE +: SLICE];
  assign {w_bout, w_diff} = {1'b0, w_a_sl} - {1'b0, w_b_sl} - {{SLICE{1'b0}}, r_bin};

  // Only meaningful on the last slice, where w_diff holds the result's sign bit.
  assign w_ovf = r_signed & (r_a[WIDTH-1] ^ r_b[WIDTH-1]) & (w_diff[SLICE-1] ^ r_a[WIDTH-1]);

  // NOTE: operand and result registers are reset too, so post-reset contents are deterministic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_signed <= 1'b0;
      r_cnt    <= '0;
      r_bin    <= 1'b0;
      r_z      <= '0;
      r_borrow <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_accept) begin
      r_a      <= A;
      r_b      <= B;
      r_signed <= is_signed;
      r_cnt    <= '0;
      r_bin    <= 1'b0;
    end else if (r_state == BUSY) begin
      r_z[int'(r_cnt) * SLICE +: SLICE] <= w_diff;
      r_bin <= w_bout;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        r_borrow <= w_bout;
        r_ovf    <= w_ovf;
`ifdef SUB1_SAT_EN
        // Whole-word assignments below take precedence over the slice write above.
        if (!r_signed && w_bout)
          r_z <= '0;
        else if (w_ovf)
          r_z <= r_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
      end
    end
  end

  assign Z      = r_z;
  assign borrow = r_borrow;
  assign ovf    = r_ovf;

endmodule
